// File: rtl/rename_pkg.sv
// -----------------------------------------------------------------------------
// rename_pkg
// Shared constants and types for the speculative register rename table.
// Holds the default configuration (8 aregs, 32 pregs, 3-wide rename,
// 3 writeback ports, 3 retire slots), the derived index widths, and the
// map entry layout {preg, rdy} for the default configuration.
// -----------------------------------------------------------------------------
package rename_pkg;

   localparam int AREG_NUM_DEF  = 8;
   localparam int PREG_NUM_DEF  = 32;
   localparam int RN_WIDTH_DEF  = 3;
   localparam int WB_PORTS_DEF  = 3;
   localparam int RET_WIDTH_DEF = 3;

   localparam int AW_DEF = $clog2(AREG_NUM_DEF);
   localparam int PW_DEF = $clog2(PREG_NUM_DEF);
   localparam int CW_DEF = $clog2(PREG_NUM_DEF + 1);

   // One speculative map entry: current physical register and whether its
   // value has already been produced.
   typedef struct packed {
      logic [PW_DEF-1:0] preg;
      logic              rdy;
   } map_entry_t;

endpackage

// File: rtl/rename_map_table_free_list_alloc.sv
// -----------------------------------------------------------------------------
// free_list_alloc
// Picks destination pregs for one rename group from the free-list bitmap.
// Slot 0 takes the lowest free preg, each later needing slot takes the lowest
// preg not already taken by an older slot. Preg 0 is never handed out.
// Also returns how many slots asked for a preg.
//
// Ports:
//   free_i    PREG_NUM-bit free bitmap (1 = free)
//   need_i    per-slot allocation request
//   pw_o      per-slot allocated preg (0 when the slot does not need one)
//   n_need_o  popcount of need_i
// -----------------------------------------------------------------------------
module free_list_alloc
   import rename_pkg::*;
#(
   parameter  int PREG_NUM = PREG_NUM_DEF,
   parameter  int RN_WIDTH = RN_WIDTH_DEF,
   localparam int PW       = $clog2(PREG_NUM),
   localparam int NW       = $clog2(RN_WIDTH + 1)
) (
   input  logic [PREG_NUM-1:0]         free_i,
   input  logic [RN_WIDTH-1:0]         need_i,
   output logic [RN_WIDTH-1:0][PW-1:0] pw_o,
   output logic [NW-1:0]               n_need_o
);

   logic [PREG_NUM-1:0] avail;
   logic [PW-1:0]       pick;
   logic                hit;

   // Chained lowest-set-bit pickers: each slot masks out what it took before
   // the next slot searches.
   always_comb begin
      avail    = free_i;
      avail[0] = 1'b0;
      pw_o     = '0;
      pick     = '0;
      hit      = 1'b0;
      for (int k = 0; k < RN_WIDTH; k++) begin
         pick = '0;
         hit  = 1'b0;
         for (int i = PREG_NUM - 1; i >= 0; i--) begin
            if (avail[i]) begin
               pick = PW'(i);
               hit  = 1'b1;
            end
         end
         if (need_i[k] && hit) begin
            pw_o[k]     = pick;
            avail[pick] = 1'b0;
         end
      end
   end

   always_comb begin
      n_need_o = '0;
      for (int k = 0; k < RN_WIDTH; k++) begin
         n_need_o = n_need_o + NW'(need_i[k]);
      end
   end

endmodule

// File: rtl/rename_map_table.sv
// -----------------------------------------------------------------------------
// rename_map_table
// Speculative architectural-to-physical register map for the rename stage.
// Holds the map (preg + ready per areg), the physical free list and a
// registered free counter. Renames RN_WIDTH instructions per cycle with
// intra-group forwarding, wakes operands on writeback broadcasts, releases
// old mappings on in-order retirement, and restores from the committed
// (architectural) table on flush.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ren_go / ren_ready            group presented / enough free pregs
//   ren_dst, ren_ra/rb/rw         per-slot dest flag and source/dest aregs
//   ren_pa/pb, ren_pa/pb_rdy      renamed sources and their readiness
//   ren_pw, ren_pw_old            new and previous destination preg
//   wb_valid, wb_preg             writeback wakeup broadcasts
//   ret_valid/excep/pw_old        retire slots and pregs to release
//   flush, arat_map, arat_free    precise-exception recovery state
//   free_cnt                      registered free preg count
//
// Build option RMT_WB_BYPASS_EN: when defined, source readiness also reflects
// same-cycle writeback broadcasts; otherwise a wakeup is seen next cycle.
// -----------------------------------------------------------------------------
module rename_map_table
   import rename_pkg::*;
#(
   parameter  int AREG_NUM  = AREG_NUM_DEF,
   parameter  int PREG_NUM  = PREG_NUM_DEF,
   parameter  int RN_WIDTH  = RN_WIDTH_DEF,
   parameter  int WB_PORTS  = WB_PORTS_DEF,
   parameter  int RET_WIDTH = RET_WIDTH_DEF,
   localparam int AW        = $clog2(AREG_NUM),
   localparam int PW        = $clog2(PREG_NUM),
   localparam int CW        = $clog2(PREG_NUM + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ren_go,
   output logic                          ren_ready,
   input  logic [RN_WIDTH-1:0]           ren_dst,
   input  logic [RN_WIDTH-1:0][AW-1:0]   ren_ra,
   input  logic [RN_WIDTH-1:0][AW-1:0]   ren_rb,
   input  logic [RN_WIDTH-1:0][AW-1:0]   ren_rw,
   output logic [RN_WIDTH-1:0][PW-1:0]   ren_pa,
   output logic [RN_WIDTH-1:0][PW-1:0]   ren_pb,
   output logic [RN_WIDTH-1:0]           ren_pa_rdy,
   output logic [RN_WIDTH-1:0]           ren_pb_rdy,
   output logic [RN_WIDTH-1:0][PW-1:0]   ren_pw,
   output logic [RN_WIDTH-1:0][PW-1:0]   ren_pw_old,
   input  logic [WB_PORTS-1:0]           wb_valid,
   input  logic [WB_PORTS-1:0][PW-1:0]   wb_preg,
   input  logic [RET_WIDTH-1:0]          ret_valid,
   input  logic [RET_WIDTH-1:0]          ret_excep,
   input  logic [RET_WIDTH-1:0][PW-1:0]  ret_pw_old,
   input  logic                          flush,
   input  logic [AREG_NUM-1:0][PW-1:0]   arat_map,
   input  logic [PREG_NUM-1:0]           arat_free,
   output logic [CW-1:0]                 free_cnt
);

   localparam int NW = $clog2(RN_WIDTH + 1);
   localparam int RW = $clog2(RET_WIDTH + 1);
   localparam logic [PREG_NUM-1:0] RST_FREE = {PREG_NUM{1'b1}} << AREG_NUM;

   // Same layout as rename_pkg::map_entry_t, sized for this instance.
   typedef struct packed {
      logic [PW-1:0] preg;
      logic          rdy;
   } ent_t;

   ent_t [AREG_NUM-1:0]         map_q, map_d;
   logic [PREG_NUM-1:0]         free_q, free_d;
   logic [CW-1:0]               cnt_q, cnt_d;

   logic [RN_WIDTH-1:0]         need;
   logic [NW-1:0]               n_need;
   logic                        commit;
   ent_t [RN_WIDTH-1:0]         src_a, src_b;
   logic [RN_WIDTH-1:0]         fwd_a, fwd_b;
   logic [RN_WIDTH-1:0]         byp_a, byp_b;
   logic [RN_WIDTH-1:0][PW-1:0] old_pw;
   logic [RET_WIDTH-1:0]        rel_mask;
   logic [RW-1:0]               rel_n;
   logic                        rel_ok;
   logic [CW-1:0]               flush_cnt;

   // Areg 0 is hardwired, so a write to it never consumes a preg.
   always_comb begin
      for (int k = 0; k < RN_WIDTH; k++) begin
         need[k] = ren_dst[k] && (ren_rw[k] != '0);
      end
   end

   free_list_alloc #(
      .PREG_NUM (PREG_NUM),
      .RN_WIDTH (RN_WIDTH)
   ) u_alloc (
      .free_i   (free_q),
      .need_i   (need),
      .pw_o     (ren_pw),
      .n_need_o (n_need)
   );

   assign ren_ready = !flush && (cnt_q >= CW'(n_need));
   assign commit    = ren_go && ren_ready;
   assign free_cnt  = cnt_q;

   // Table lookup with intra-group forwarding. Scanning older slots from
   // oldest to youngest lets the youngest matching writer win.
   always_comb begin
      for (int k = 0; k < RN_WIDTH; k++) begin
         src_a[k]  = map_q[ren_ra[k]];
         src_b[k]  = map_q[ren_rb[k]];
         old_pw[k] = map_q[ren_rw[k]].preg;
         fwd_a[k]  = 1'b0;
         fwd_b[k]  = 1'b0;
         for (int j = 0; j < k; j++) begin
            if (ren_dst[j] && (ren_rw[j] != '0)) begin
               if (ren_rw[j] == ren_ra[k]) begin
                  src_a[k] = '{preg: ren_pw[j], rdy: 1'b0};
                  fwd_a[k] = 1'b1;
               end
               if (ren_rw[j] == ren_rb[k]) begin
                  src_b[k] = '{preg: ren_pw[j], rdy: 1'b0};
                  fwd_b[k] = 1'b1;
               end
               if (ren_rw[j] == ren_rw[k]) begin
                  old_pw[k] = ren_pw[j];
               end
            end
         end
      end
   end

   // Same-cycle wakeup only applies to values read from the table; a value
   // forwarded from an older slot in the group cannot have been produced yet.
   always_comb begin
      byp_a = '0;
      byp_b = '0;
`ifdef RMT_WB_BYPASS_EN
      for (int k = 0; k < RN_WIDTH; k++) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_preg[p] == src_a[k].preg)) byp_a[k] = 1'b1;
            if (wb_valid[p] && (wb_preg[p] == src_b[k].preg)) byp_b[k] = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      for (int k = 0; k < RN_WIDTH; k++) begin
         ren_pa[k]     = src_a[k].preg;
         ren_pb[k]     = src_b[k].preg;
         ren_pa_rdy[k] = src_a[k].rdy | (byp_a[k] & ~fwd_a[k]);
         ren_pb_rdy[k] = src_b[k].rdy | (byp_b[k] & ~fwd_b[k]);
         ren_pw_old[k] = old_pw[k];
      end
   end

   // Retirement releases an in-order prefix; the first invalid or excepting
   // slot stops everything younger. Releasing preg 0 is dropped.
   always_comb begin
      rel_ok   = 1'b1;
      rel_mask = '0;
      rel_n    = '0;
      for (int k = 0; k < RET_WIDTH; k++) begin
         rel_ok = rel_ok & ret_valid[k] & ~ret_excep[k];
         if (rel_ok && (ret_pw_old[k] != '0)) begin
            rel_mask[k] = 1'b1;
            rel_n       = rel_n + RW'(1);
         end
      end
   end

   always_comb begin
      flush_cnt = '0;
      for (int i = 0; i < PREG_NUM; i++) begin
         flush_cnt = flush_cnt + CW'(arat_free[i]);
      end
   end

   always_comb begin
      map_d  = map_q;
      free_d = free_q;
      cnt_d  = cnt_q;
      if (flush) begin
         for (int i = 0; i < AREG_NUM; i++) begin
            map_d[i] = '{preg: arat_map[i], rdy: 1'b1};
         end
         free_d = arat_free;
         cnt_d  = flush_cnt;
      end else begin
         // Wakeup first so a same-cycle rename of the entry overrides it.
         for (int i = 0; i < AREG_NUM; i++) begin
            for (int p = 0; p < WB_PORTS; p++) begin
               if (wb_valid[p] && (wb_preg[p] != '0) && (map_q[i].preg == wb_preg[p])) begin
                  map_d[i].rdy = 1'b1;
               end
            end
         end
         if (commit) begin
            for (int k = 0; k < RN_WIDTH; k++) begin
               if (need[k]) begin
                  map_d[ren_rw[k]]   = '{preg: ren_pw[k], rdy: 1'b0};
                  free_d[ren_pw[k]]  = 1'b0;
               end
            end
         end
         for (int k = 0; k < RET_WIDTH; k++) begin
            if (rel_mask[k]) free_d[ret_pw_old[k]] = 1'b1;
         end
         cnt_d = cnt_q + CW'(rel_n) - (commit ? CW'(n_need) : CW'(0));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < AREG_NUM; i++) begin
            map_q[i] <= '{preg: PW'(i), rdy: 1'b1};
         end
         free_q <= RST_FREE;
         cnt_q  <= CW'(PREG_NUM - AREG_NUM);
      end else begin
         map_q  <= map_d;
         free_q <= free_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table. The stimulus process drives one cycle
// at a time and queues the values it expects to see that cycle; a separate
// monitor samples on the falling edge and compares against the queue.
module tb_rename_map_table;
   localparam int RN = 3, AW = 3, PW = 5, CW = 6, AREGS = 8, PREGS = 32;
`ifdef RMT_WB_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif
   localparam int S_RDY = 0, S_PA = 1, S_PARDY = 2, S_PB = 3, S_PBRDY = 4,
                  S_PW = 5, S_PWOLD = 6, S_CNT = 7;

   logic clk = 1'b0, rst;
   logic ren_go, ren_ready;
   logic [RN-1:0] ren_dst, ren_pa_rdy, ren_pb_rdy;
   logic [RN-1:0][AW-1:0] ren_ra, ren_rb, ren_rw;
   logic [RN-1:0][PW-1:0] ren_pa, ren_pb, ren_pw, ren_pw_old;
   logic [2:0] wb_valid, ret_valid, ret_excep;
   logic [2:0][PW-1:0] wb_preg, ret_pw_old;
   logic flush;
   logic [AREGS-1:0][PW-1:0] arat_map;
   logic [PREGS-1:0] arat_free;
   logic [CW-1:0] free_cnt;

   rename_map_table dut (
      .clk(clk), .rst(rst), .ren_go(ren_go), .ren_ready(ren_ready),
      .ren_dst(ren_dst), .ren_ra(ren_ra), .ren_rb(ren_rb), .ren_rw(ren_rw),
      .ren_pa(ren_pa), .ren_pb(ren_pb), .ren_pa_rdy(ren_pa_rdy), .ren_pb_rdy(ren_pb_rdy),
      .ren_pw(ren_pw), .ren_pw_old(ren_pw_old), .wb_valid(wb_valid), .wb_preg(wb_preg),
      .ret_valid(ret_valid), .ret_excep(ret_excep), .ret_pw_old(ret_pw_old),
      .flush(flush), .arat_map(arat_map), .arat_free(arat_free), .free_cnt(free_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; string name; int sel; int idx; int exp; } exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0;

   function automatic int act(int sel, int idx);
      case (sel)
         S_RDY:   return int'(ren_ready);
         S_PA:    return int'(ren_pa[idx]);
         S_PARDY: return int'(ren_pa_rdy[idx]);
         S_PB:    return int'(ren_pb[idx]);
         S_PBRDY: return int'(ren_pb_rdy[idx]);
         S_PW:    return int'(ren_pw[idx]);
         S_PWOLD: return int'(ren_pw_old[idx]);
         default: return int'(free_cnt);
      endcase
   endfunction

   task automatic chk(input string nm, input int sel, input int idx, input int v);
      sb.push_back('{cyc, nm, sel, idx, v});
   endtask

   // Monitor: compare everything queued for the current cycle.
   initial begin
      exp_t e;
      int a;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            a = act(e.sel, e.idx);
            checks++;
            if (a != e.exp) begin
               errors++;
               $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
            end
         end
      end
   end

   task automatic idle();
      ren_go = 0; ren_dst = '0; ren_ra = '0; ren_rb = '0; ren_rw = '0;
      wb_valid = '0; wb_preg = '0; ret_valid = '0; ret_excep = '0; ret_pw_old = '0;
      flush = 0; arat_free = '0;
      for (int i = 0; i < AREGS; i++) arat_map[i] = PW'(i);
   endtask

   task automatic nxt();
      @(posedge clk); #1; idle();
   endtask

   task automatic grp(input logic [2:0] dst, input int w0, input int w1, input int w2);
      ren_go = 1; ren_dst = dst;
      ren_rw[0] = AW'(w0); ren_rw[1] = AW'(w1); ren_rw[2] = AW'(w2);
   endtask

   initial begin
      rst = 0; idle();
      repeat (2) @(posedge clk); #1;
      // reset state
      ren_ra[0] = 1; ren_ra[1] = 2; ren_ra[2] = 7;
      chk("rst_cnt", S_CNT, 0, 24); chk("rst_pa0", S_PA, 0, 1);
      chk("rst_pa2", S_PA, 2, 7); chk("rst_pardy0", S_PARDY, 0, 1);
      chk("rst_ready", S_RDY, 0, 1);

      // 1: three allocations, slot2 rewrites slot0's areg
      nxt(); rst = 1; grp(3'b111, 1, 2, 1);
      chk("t1_pw0", S_PW, 0, 8); chk("t1_pw1", S_PW, 1, 9); chk("t1_pw2", S_PW, 2, 10);
      chk("t1_pwold0", S_PWOLD, 0, 1); chk("t1_pwold1", S_PWOLD, 1, 2);
      chk("t1_pwold2", S_PWOLD, 2, 8); chk("t1_ready", S_RDY, 0, 1);
      nxt(); ren_ra[0] = 1; ren_ra[1] = 2;
      chk("t1_map1", S_PA, 0, 10); chk("t1_rdy1", S_PARDY, 0, 0);
      chk("t1_map2", S_PA, 1, 9); chk("t1_cnt", S_CNT, 0, 21);

      // 2: intra-group forwarding, areg 0 never forwarded
      nxt(); grp(3'b001, 3, 0, 0); ren_ra[1] = 3; ren_rb[1] = 0; ren_ra[2] = 3;
      chk("t2_pw0", S_PW, 0, 11); chk("t2_pa1", S_PA, 1, 11); chk("t2_pardy1", S_PARDY, 1, 0);
      chk("t2_pb1", S_PB, 1, 0); chk("t2_pbrdy1", S_PBRDY, 1, 1); chk("t2_pa2", S_PA, 2, 11);
      nxt(); ren_ra[0] = 3;
      chk("t2_map3", S_PA, 0, 11); chk("t2_rdy3", S_PARDY, 0, 0); chk("t2_cnt", S_CNT, 0, 20);

      // 4: wakeup racing a rename of the same areg, then plain wakeup
      nxt(); grp(3'b001, 1, 0, 0); wb_valid = 3'b001; wb_preg[0] = 10;
      chk("t4_pw0", S_PW, 0, 12); chk("t4_pwold0", S_PWOLD, 0, 10);
      nxt(); ren_ra[0] = 1;
      chk("t4_map1", S_PA, 0, 12); chk("t4_rdy_new", S_PARDY, 0, 0); chk("t4_cnt", S_CNT, 0, 19);
      nxt(); ren_ra[0] = 1; ren_ra[1] = 2; wb_valid = 3'b110; wb_preg[1] = 12; wb_preg[2] = 9;
      chk("t4_byp0", S_PARDY, 0, BYP); chk("t4_byp1", S_PARDY, 1, BYP);
      nxt(); ren_ra[0] = 1; ren_ra[1] = 2; ren_ra[2] = 3;
      chk("t4_woke1", S_PARDY, 0, 1); chk("t4_woke2", S_PARDY, 1, 1);
      chk("t4_map3", S_PA, 2, 11); chk("t4_rdy3", S_PARDY, 2, 0);

      // 5: retire prefix rules
      nxt(); ret_valid = 3'b111; ret_excep = 3'b010;
      ret_pw_old[0] = 10; ret_pw_old[1] = 8; ret_pw_old[2] = 2;
      nxt(); chk("t5_cnt_a", S_CNT, 0, 20); ret_valid = 3'b110;
      ret_pw_old[0] = 8; ret_pw_old[1] = 1; ret_pw_old[2] = 3;
      nxt(); chk("t5_cnt_b", S_CNT, 0, 20); ret_valid = 3'b111; ret_excep = 3'b100;
      ret_pw_old[0] = 0; ret_pw_old[1] = 8; ret_pw_old[2] = 3;
      nxt(); chk("t5_cnt_c", S_CNT, 0, 21);

      // 3: drain the free list down to 2, then stall and partial groups
      grp(3'b111, 4, 5, 6);
      chk("t3_reuse0", S_PW, 0, 8); chk("t3_reuse1", S_PW, 1, 10); chk("t3_reuse2", S_PW, 2, 13);
      for (int n = 0; n < 5; n++) begin nxt(); grp(3'b111, 4, 5, 6); end
      nxt(); grp(3'b001, 7, 0, 0); chk("t3_cnt3", S_CNT, 0, 3); chk("t3_pw29", S_PW, 0, 29);
      nxt(); grp(3'b111, 1, 2, 3); chk("t3_stall", S_RDY, 0, 0); chk("t3_cnt2", S_CNT, 0, 2);
      nxt(); grp(3'b111, 1, 2, 0); ren_ra[0] = 1;
      chk("t3_nochg_cnt", S_CNT, 0, 2); chk("t3_nochg_map", S_PA, 0, 12);
      chk("t3_ready2", S_RDY, 0, 1); chk("t3_pw0", S_PW, 0, 30);
      chk("t3_pw1", S_PW, 1, 31); chk("t3_pw2", S_PW, 2, 0);
      nxt(); grp(3'b000, 0, 0, 0); ren_ra[0] = 1; ren_ra[1] = 2;
      chk("t3_cnt0", S_CNT, 0, 0); chk("t3_map1", S_PA, 0, 30); chk("t3_map2", S_PA, 1, 31);
      chk("t3_ready_none", S_RDY, 0, 1);
      nxt(); grp(3'b001, 1, 0, 0); chk("t3_empty_stall", S_RDY, 0, 0);

      // 6: flush restores committed state and blocks the group
      nxt(); grp(3'b111, 1, 2, 3); flush = 1; arat_free = 32'hFFFF_FF00;
      wb_valid = 3'b001; wb_preg[0] = 30; ret_valid = 3'b001; ret_pw_old[0] = 5;
      chk("t6_ready", S_RDY, 0, 0);
      nxt(); ren_ra[0] = 1; ren_ra[1] = 2; ren_ra[2] = 3; grp(3'b001, 5, 0, 0);
      chk("t6_cnt", S_CNT, 0, 24); chk("t6_pa0", S_PA, 0, 1); chk("t6_pardy0", S_PARDY, 0, 1);
      chk("t6_pa2", S_PA, 2, 3); chk("t6_pardy2", S_PARDY, 2, 1);
      chk("t6_pw0", S_PW, 0, 8); chk("t6_pwold0", S_PWOLD, 0, 5);
      nxt(); ren_ra[0] = 5; chk("t6_cnt23", S_CNT, 0, 23); chk("t6_map5", S_PA, 0, 8);

      // asynchronous reset in the middle of a cycle
      nxt(); ren_ra[0] = 5; #2; rst = 0;
      chk("mrst_cnt", S_CNT, 0, 24); chk("mrst_map5", S_PA, 0, 5); chk("mrst_rdy5", S_PARDY, 0, 1);
      nxt(); rst = 1;

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
